// File: rtl/datapath_fifo_pkg.sv
// Shared definitions for the datapath capture FIFO and related rate-limited paths.
//   SAMPLE_W        : width of one datapath sample
//   BEAT_W          : width of one host beat
//   HALF_W          : width of the upper sample slice and of the optional timestamp
//   CLK_DIV_DEFAULT : default sample strobe period in clk cycles
//   beat_ph_e       : which half of a stored entry the next host read returns
package datapath_fifo_pkg;

    localparam int unsigned SAMPLE_W        = 192;
    localparam int unsigned BEAT_W          = 128;
    localparam int unsigned HALF_W          = 64;
    localparam int unsigned CLK_DIV_DEFAULT = 30;

    typedef enum logic {
        BEAT_LO = 1'b0,
        BEAT_HI = 1'b1
    } beat_ph_e;

endpackage

// File: rtl/sample_strobe_gen.sv
// Sample-rate strobe generator: a 6-bit counter that wraps CLK_DIV-1 -> 0 and
// asserts strobe while it holds CLK_DIV-1 (first strobe CLK_DIV cycles after reset).
// Ports:
//   clk    : system clock
//   rstn   : synchronous active-low reset
//   strobe : one-cycle pulse every CLK_DIV clocks
module sample_strobe_gen
    import datapath_fifo_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rstn,
    output logic strobe
);

    localparam logic [5:0] CNT_LAST = 6'(CLK_DIV - 1);

    logic [5:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 6'd1;
        end
    end

    assign strobe = (cnt_q == CNT_LAST);

endmodule

// File: rtl/datapath_capture_fifo.sv
// Return-path capture FIFO: stores 192-bit datapath samples at the divided
// sample rate and hands them to the host as two 128-bit beats
// (beat 0 = sample[127:0], beat 1 = {upper, sample[191:128]}).
// Optional feature macro CAPTURE_FIFO_TIMESTAMP_EN: a 64-bit free-running cycle
// counter is stored with each sample and returned as the upper half of beat 1;
// otherwise that half is zero.
// Ports:
//   clk, rstn   : clock, synchronous active-low reset
//   wr, data_in : capture request and sample (accepted only on a strobe, when not full)
//   rd          : host beat read request
//   wr_en_100ns : combinational pulse, sample accepted this cycle
//   data_out    : registered beat; data_valid marks the cycle it was updated
//   data_count  : stored entries 0..DEPTH
//   full, empty, threshold : registered level flags
//   overflow, underflow    : sticky rejected-write / rejected-read flags
module datapath_capture_fifo
    import datapath_fifo_pkg::*;
#(
    parameter int unsigned INPUT_DATA_WIDTH  = SAMPLE_W,
    parameter int unsigned OUTPUT_DATA_WIDTH = BEAT_W,
    parameter int unsigned DEPTH             = 1024,
    parameter int unsigned DEPTH_SIZE        = 10,
    parameter int unsigned CLK_DIV           = CLK_DIV_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         wr,
    input  logic [INPUT_DATA_WIDTH-1:0]  data_in,
    input  logic                         rd,
    output logic                         wr_en_100ns,
    output logic [OUTPUT_DATA_WIDTH-1:0] data_out,
    output logic                         data_valid,
    output logic [DEPTH_SIZE:0]          data_count,
    output logic                         full,
    output logic                         empty,
    output logic                         threshold,
    output logic                         overflow,
    output logic                         underflow
);

`ifdef CAPTURE_FIFO_TIMESTAMP_EN
    localparam int unsigned MEM_W = SAMPLE_W + HALF_W;
`else
    localparam int unsigned MEM_W = SAMPLE_W;
`endif

    localparam logic [DEPTH_SIZE:0] PTR_ONE   = (DEPTH_SIZE + 1)'(1);
    localparam logic [DEPTH_SIZE:0] CNT_FULL  = (DEPTH_SIZE + 1)'(DEPTH);
    localparam logic [DEPTH_SIZE:0] CNT_HALF  = (DEPTH_SIZE + 1)'(DEPTH / 2);

    logic [MEM_W-1:0]      mem [DEPTH];
    logic [MEM_W-1:0]      wr_word;
    logic [MEM_W-1:0]      rd_word;
    logic [HALF_W-1:0]     hi_ext;
    logic [BEAT_W-1:0]     beat;

    logic [DEPTH_SIZE:0]   w_ptr_q, w_ptr_d;
    logic [DEPTH_SIZE:0]   r_ptr_q, r_ptr_d;
    logic [DEPTH_SIZE:0]   count_d;
    beat_ph_e              ph_q, ph_d;

    logic strobe;
    logic full_int, empty_int;
    logic wr_en, rd_en, pop;

    sample_strobe_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_strobe (
        .clk    (clk),
        .rstn   (rstn),
        .strobe (strobe)
    );

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full_int  = (w_ptr_q[DEPTH_SIZE] != r_ptr_q[DEPTH_SIZE]) &&
                       (w_ptr_q[DEPTH_SIZE-1:0] == r_ptr_q[DEPTH_SIZE-1:0]);
    assign empty_int = (w_ptr_q == r_ptr_q);

    assign wr_en       = wr & strobe & ~full_int;
    assign rd_en       = rd & ~empty_int;
    assign pop         = rd_en & (ph_q == BEAT_HI);
    assign wr_en_100ns = wr_en;

`ifdef CAPTURE_FIFO_TIMESTAMP_EN
    logic [HALF_W-1:0] ts_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 64'd1;
        end
    end

    assign wr_word = {ts_q, data_in};
    assign hi_ext  = rd_word[MEM_W-1:SAMPLE_W];
`else
    assign wr_word = data_in;
    assign hi_ext  = '0;
`endif

    assign rd_word = mem[r_ptr_q[DEPTH_SIZE-1:0]];

    // Storage is not reset; only pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[w_ptr_q[DEPTH_SIZE-1:0]] <= wr_word;
        end
    end

    // Next-state: beat phase and pointers. An entry is freed only on its beat-1 read.
    always_comb begin
        ph_d    = ph_q;
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        if (wr_en) begin
            w_ptr_d = w_ptr_q + PTR_ONE;
        end
        if (rd_en) begin
            if (ph_q == BEAT_LO) begin
                ph_d = BEAT_HI;
            end else begin
                ph_d    = BEAT_LO;
                r_ptr_d = r_ptr_q + PTR_ONE;
            end
        end
    end

    assign count_d = w_ptr_d - r_ptr_d;

    // Output select for the beat returned by the current phase.
    always_comb begin
        beat = rd_word[BEAT_W-1:0];
        if (ph_q == BEAT_HI) begin
            beat = {hi_ext, rd_word[SAMPLE_W-1:BEAT_W]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            w_ptr_q    <= '0;
            r_ptr_q    <= '0;
            ph_q       <= BEAT_LO;
            data_out   <= '0;
            data_valid <= 1'b0;
            data_count <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            threshold  <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            w_ptr_q    <= w_ptr_d;
            r_ptr_q    <= r_ptr_d;
            ph_q       <= ph_d;
            data_valid <= rd_en;
            if (rd_en) begin
                data_out <= beat;
            end
            // Flags track the post-update pointers so they agree with data_count.
            data_count <= count_d;
            full       <= (count_d == CNT_FULL);
            empty      <= (count_d == '0);
            threshold  <= (count_d >= CNT_HALF);
            // Sticky flags: set has priority over clear.
            if (wr & strobe & full_int) begin
                overflow <= 1'b1;
            end else if (pop) begin
                overflow <= 1'b0;
            end
            if (rd & empty_int) begin
                underflow <= 1'b1;
            end else if (wr_en) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_datapath_capture_fifo.sv
// Self-checking bench for datapath_capture_fifo (DEPTH=16, CLK_DIV=30).
// A cycle-level reference model predicts flags and beats; expected beats are
// queued when a read is issued and a monitor checks them when data_valid rises.
// Build with +define+CAPTURE_FIFO_TIMESTAMP_EN to exercise the timestamp variant.
module tb_datapath_capture_fifo;

    localparam int unsigned DEPTH   = 16;
    localparam int unsigned DSIZE   = 4;
    localparam int unsigned CLK_DIV = 30;

    logic           clk = 1'b0;
    logic           rstn;
    logic           wr;
    logic [191:0]   data_in;
    logic           rd;
    logic           wr_en_100ns;
    logic [127:0]   data_out;
    logic           data_valid;
    logic [DSIZE:0] data_count;
    logic           full, empty, threshold, overflow, underflow;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state.
    logic [255:0] mq[$];
    logic [127:0] exp_q[$];
    logic [127:0] exp_dout;
    int           mcnt;
    logic [63:0]  tsm;
    logic         ph_m, ovf_m, udf_m;

    datapath_capture_fifo #(
        .DEPTH      (DEPTH),
        .DEPTH_SIZE (DSIZE),
        .CLK_DIV    (CLK_DIV)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .wr          (wr),
        .data_in     (data_in),
        .rd          (rd),
        .wr_en_100ns (wr_en_100ns),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_count  (data_count),
        .full        (full),
        .empty       (empty),
        .threshold   (threshold),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every presented beat must match the oldest expectation.
    always @(negedge clk) begin
        if (rstn && data_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected beat", {128'h0, data_out}, 256'h0);
                if (data_out == '0) begin
                    n_fail++;
                    $display("FAIL unexpected beat: got data_valid=1 expected 0");
                end
            end else begin
                chk("beat", {128'h0, data_out}, {128'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic check_regs();
        chk("data_count", 256'(data_count), 256'(mq.size()));
        chk("full",       256'(full),       256'(mq.size() == DEPTH));
        chk("empty",      256'(empty),      256'(mq.size() == 0));
        chk("threshold",  256'(threshold),  256'(mq.size() >= DEPTH / 2));
        chk("overflow",   256'(overflow),   256'(ovf_m));
        chk("underflow",  256'(underflow),  256'(udf_m));
    endtask

    // One clock cycle with the given inputs, checked against the model.
    task automatic step(input logic w, input logic r, input logic [191:0] d);
        logic         strobe_m, wr_en_m, rd_en_m, pop_m, full_m;
        logic [127:0] b;
        logic [255:0] e;
        wr = w; rd = r; data_in = d;
        strobe_m = (mcnt == CLK_DIV - 1);
        full_m   = (mq.size() == DEPTH);
        wr_en_m  = w && strobe_m && !full_m;
        rd_en_m  = r && (mq.size() != 0);
        pop_m    = rd_en_m && ph_m;
        #1;
        chk("wr_en_100ns", 256'(wr_en_100ns), 256'(wr_en_m));
        if (rd_en_m) begin
            e = mq[0];
            b = ph_m ? {e[255:192], e[191:128]} : e[127:0];
            exp_q.push_back(b);
            exp_dout = b;
        end
        if (w && strobe_m && full_m) ovf_m = 1'b1;
        else if (pop_m)              ovf_m = 1'b0;
        if (r && mq.size() == 0)     udf_m = 1'b1;
        else if (wr_en_m)            udf_m = 1'b0;
        if (pop_m) void'(mq.pop_front());
`ifdef CAPTURE_FIFO_TIMESTAMP_EN
        if (wr_en_m) mq.push_back({tsm, d});
`else
        if (wr_en_m) mq.push_back({64'h0, d});
`endif
        if (rd_en_m) ph_m = !ph_m;
        @(posedge clk);
        #1;
        mcnt = (mcnt == CLK_DIV - 1) ? 0 : mcnt + 1;
        tsm  = tsm + 64'd1;
        chk("data_valid", 256'(data_valid), 256'(rd_en_m));
        if (!rd_en_m) chk("data_out hold", {128'h0, data_out}, {128'h0, exp_dout});
        check_regs();
        wr = 1'b0; rd = 1'b0;
    endtask

    task automatic reset_pulse();
        rstn = 1'b0; wr = 1'b0; rd = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        mcnt = 0; tsm = '0; ph_m = 1'b0; ovf_m = 1'b0; udf_m = 1'b0;
        mq.delete(); exp_dout = '0;
        chk("rst data_out",    {128'h0, data_out}, 256'h0);
        chk("rst data_valid",  256'(data_valid),  256'h0);
        chk("rst wr_en_100ns", 256'(wr_en_100ns), 256'h0);
        check_regs();
    endtask

    // Hold wr high until the model says the sample was accepted (bounded).
    task automatic write_sample(input logic [191:0] d);
        bit done = 0;
        for (int n = 0; n < 2 * CLK_DIV && !done; n++) begin
            done = (mcnt == CLK_DIV - 1) && (mq.size() < DEPTH);
            step(1'b1, 1'b0, d);
        end
        if (!done) begin
            n_chk++; n_fail++;
            $display("FAIL write timeout: got no accept expected accept");
        end
    endtask

    task automatic idle_to_strobe();
        while (mcnt != CLK_DIV - 1) step(1'b0, 1'b0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [191:0] sa, sb, sc;
        sa = {64'hAAAA_AAAA_AAAA_AAAA, 128'h1111_1111_1111_1111_1111_1111_1111_1111};
        sb = {64'h0123_4567_89AB_CDEF, 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978};
        sc = {64'h5555_0000_5555_0000, 128'h2222_3333_4444_5555_6666_7777_8888_9999};
        rstn = 1'b0; wr = 1'b0; rd = 1'b0; data_in = '0;
        @(posedge clk);
        reset_pulse();

        // wr held high: accepts only at cycles 30 and 60 after release.
        for (int i = 0; i < CLK_DIV; i++) step(1'b1, 1'b0, sa);
        for (int i = 0; i < CLK_DIV; i++) step(1'b1, 1'b0, sb);
        // Four beats back to back, then drained.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);

        // Read while empty -> underflow, no data_valid, data_out held.
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);
        write_sample(sc);

        // Fill to DEPTH (pointers wrap), threshold from 8 entries.
        for (int i = 1; i < DEPTH; i++) begin
            write_sample({64'(i) ^ 64'hC0C0_C0C0_C0C0_C0C0, 64'(i * 3), 64'(i * 7 + 1)});
        end
        // Write attempt while full -> rejected, overflow set.
        idle_to_strobe();
        step(1'b1, 1'b0, sa);
        step(1'b0, 1'b1, '0);
        // Pop coincides with a rejected strobe write: overflow stays set.
        idle_to_strobe();
        step(1'b1, 1'b1, sa);
        // A lone pop clears overflow.
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b1, '0);

        // Half-read entry discarded by reset; next sample returns beat 0 first.
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);
        reset_pulse();
        write_sample(sb);
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);

        chk("scoreboard drained", 256'(exp_q.size()), 256'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
